op_sequencer: RTL and testbench

- Control front end for the 8-bit register/operation datapath.
- Debounces the raw `setButton` and `displayButton` switches.
- Steps the operator through select-opcode, select-reg1, select-reg2 and execute, latching `opCode`, `regID1` and `regID2` from `inputs`.
- Runs a level handshake with the operation unit (`operate` → `opDone`), with a timeout. Replaces the button-clocked state register, so every flop in the block sits on `clock`.

---
 rtl/op_sequencer_if.sv | 46 ++++
 rtl/op_sequencer.sv | 178 +++++++++++++++++
 tb/tb_op_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/op_sequencer_if.sv
// Handshake/bus bundle between the operator front end (buttons, switches, op unit)
// and op_sequencer.
interface op_sequencer_if;
    logic       setButton;
    logic       displayButton;
    logic [3:0] inputs;
    logic       opDone;
    logic [2:0] Q;
    logic [3:0] opCode;
    logic [3:0] regID1;
    logic [3:0] regID2;
    logic       operate;
    logic       display;
    logic       busy;
    logic       error;

    modport master (
        output setButton,
        output displayButton,
        output inputs,
        output opDone,
        input  Q,
        input  opCode,
        input  regID1,
        input  regID2,
        input  operate,
        input  display,
        input  busy,
        input  error
    );

    modport slave (
        input  setButton,
        input  displayButton,
        input  inputs,
        input  opDone,
        output Q,
        output opCode,
        output regID1,
        output regID2,
        output operate,
        output display,
        output busy,
        output error
    );
endinterface

// File: rtl/op_sequencer.sv
// Debounced operator front end: select opcode/reg1/reg2, then execute via operate/opDone.
// Define OPSEQ_OPCODE_FILTER_EN to accept only opcodes 0 and 1 in SEL_OP.
module op_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 16,
    parameter int unsigned CNT_W           = 16
) (
    input logic           clock,
    input logic           reset,
    op_sequencer_if.slave bus
);

    localparam logic [2:0] SEL_OP  = 3'd0;
    localparam logic [2:0] SEL_R1  = 3'd1;
    localparam logic [2:0] SEL_R2  = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Button index 0 is setButton, index 1 is displayButton.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;
    logic [CNT_W-1:0] dcnt_q [2];
    logic [CNT_W-1:0] dcnt_d [2];
    logic [1:0]       press;
    logic             set_press;
    logic             disp_press;

    logic [2:0]       q_q, q_d;
    logic [3:0]       op_code_q, op_code_d;
    logic [3:0]       reg_id1_q, reg_id1_d;
    logic [3:0]       reg_id2_q, reg_id2_d;
    logic             operate_q, operate_d;
    logic             display_q, display_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             op_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            deb_q     <= 2'b11;
            dcnt_q[0] <= '0;
            dcnt_q[1] <= '0;
        end else begin
            sync1_q   <= {bus.displayButton, bus.setButton};
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            dcnt_q[0] <= dcnt_d[0];
            dcnt_q[1] <= dcnt_d[1];
        end
    end

    // The counter measures how long the synchronized level has disagreed with the
    // debounced level; any return to agreement restarts it.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press      = deb_q & ~deb_d;
    assign set_press  = press[0];
    assign disp_press = press[1];

`ifdef OPSEQ_OPCODE_FILTER_EN
    assign op_ok = (bus.inputs[3:1] == 3'b000);
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        q_d       = q_q;
        op_code_d = op_code_q;
        reg_id1_d = reg_id1_q;
        reg_id2_d = reg_id2_q;
        error_d   = error_q;
        tcnt_d    = '0;

        case (q_q)
            SEL_OP: begin
                if (set_press && op_ok) begin
                    op_code_d = bus.inputs;
                    error_d   = 1'b0;
                    q_d       = SEL_R1;
                end
            end
            SEL_R1: begin
                if (set_press && !bus.inputs[3]) begin
                    reg_id1_d = bus.inputs;
                    q_d       = SEL_R2;
                end
            end
            SEL_R2: begin
                if (set_press && !bus.inputs[3]) begin
                    reg_id2_d = bus.inputs;
                    q_d       = EXEC;
                end
            end
            EXEC: begin
                // Completion wins over a coincident terminal count.
                if (bus.opDone) begin
                    q_d = RELEASE;
                end else if (tcnt_q == TMO_LAST) begin
                    error_d = 1'b1;
                    q_d     = SEL_OP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!bus.opDone) begin
                    q_d = SEL_OP;
                end
            end
            default: q_d = SEL_OP;
        endcase

        display_d = display_q;
        if (disp_press && (q_q == SEL_R1 || q_q == SEL_R2 || q_q == EXEC)) begin
            display_d = ~display_q;
        end
        if (q_d == SEL_OP && q_q != SEL_OP) begin
            display_d = 1'b0;
        end

        operate_d = (q_d == EXEC);
        busy_d    = (q_d == EXEC) || (q_d == RELEASE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q       <= SEL_OP;
            op_code_q <= '0;
            reg_id1_q <= '0;
            reg_id2_q <= '0;
            operate_q <= 1'b0;
            display_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            q_q       <= q_d;
            op_code_q <= op_code_d;
            reg_id1_q <= reg_id1_d;
            reg_id2_q <= reg_id2_d;
            operate_q <= operate_d;
            display_q <= display_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign bus.Q       = q_q;
    assign bus.opCode  = op_code_q;
    assign bus.regID1  = reg_id1_q;
    assign bus.regID2  = reg_id2_q;
    assign bus.operate = operate_q;
    assign bus.display = display_q;
    assign bus.busy    = busy_q;
    assign bus.error   = error_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_op_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    op_sequencer_if bus ();

    op_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Press is accepted on the 6th edge (2 sync + 4 debounce), then released.
    task automatic press_set(input logic [3:0] v);
        bus.inputs    = v;
        bus.setButton = 1'b0;
        tick(6);
        bus.setButton = 1'b1;
        tick(6);
    endtask

    task automatic press_disp(input logic exp_disp, input string tag);
        bus.displayButton = 1'b0;
        tick(6);
        check_val(tag, 32'(bus.display), 32'(exp_disp));
        bus.displayButton = 1'b1;
        tick(6);
    endtask

    initial begin
        bus.setButton     = 1'b1;
        bus.displayButton = 1'b1;
        bus.inputs        = 4'h0;
        bus.opDone        = 1'b0;
        tick(3);
        check_val("rst_q", 32'(bus.Q), 32'd0);
        check_val("rst_outs", 32'({bus.opCode, bus.regID1, bus.regID2, bus.operate,
                                   bus.display, bus.busy, bus.error}), 32'd0);
        check_val("rst_deb", 32'(dut.deb_q), 32'h3);
        reset = 1'b0;
        tick(100);
        check_val("idle_q", 32'(bus.Q), 32'd0);

        // Bouncing button yields exactly one press, 6 cycles after the final edge.
        bus.inputs = 4'h1;
        for (int i = 0; i < 10; i++) begin
            bus.setButton = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        check_val("bounce_q", 32'(bus.Q), 32'd0);
        bus.setButton = 1'b0;
        tick(5);
        check_val("deb_lat5_q", 32'(bus.Q), 32'd0);
        tick(1);
        check_val("deb_lat6_q", 32'(bus.Q), 32'd1);
        check_val("deb_opcode", 32'(bus.opCode), 32'd1);
        tick(8);
        check_val("one_press_q", 32'(bus.Q), 32'd1);

        // Asynchronous reset mid-stream.
        bus.setButton = 1'b1;
        reset = 1'b1;
        #1;
        check_val("mid_rst_q", 32'(bus.Q), 32'd0);
        check_val("mid_rst_op", 32'(bus.opCode), 32'd0);
        check_val("mid_rst_deb", 32'(dut.deb_q), 32'h3);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Select sequence 0, 2, 9 (rejected), 3.
        press_set(4'h0);
        check_val("sel_op_q", 32'(bus.Q), 32'd1);
        check_val("sel_op_code", 32'(bus.opCode), 32'd0);
        press_set(4'h2);
        check_val("sel_r1_q", 32'(bus.Q), 32'd2);
        check_val("sel_r1_id", 32'(bus.regID1), 32'd2);
        press_set(4'h9);
        check_val("r2_reject_q", 32'(bus.Q), 32'd2);
        check_val("r2_reject_id", 32'(bus.regID2), 32'd0);
        bus.inputs    = 4'h3;
        bus.setButton = 1'b0;
        tick(6);
        check_val("exec_q", 32'(bus.Q), 32'd3);
        check_val("exec_r2", 32'(bus.regID2), 32'd3);
        check_val("exec_operate", 32'(bus.operate), 32'd1);
        check_val("exec_busy", 32'(bus.busy), 32'd1);
        bus.setButton = 1'b1;

        // Successful handshake.
        tick(4);
        bus.opDone = 1'b1;
        tick(1);
        check_val("done_q", 32'(bus.Q), 32'd4);
        check_val("done_operate", 32'(bus.operate), 32'd0);
        tick(2);
        check_val("release_hold_q", 32'(bus.Q), 32'd4);
        bus.opDone = 1'b0;
        tick(1);
        check_val("back_q", 32'(bus.Q), 32'd0);
        check_val("back_err", 32'(bus.error), 32'd0);
        check_val("back_busy", 32'(bus.busy), 32'd0);
        tick(4);

        // Timeout after 16 cycles in EXEC.
        press_set(4'h0);
        press_set(4'h1);
        bus.inputs    = 4'h2;
        bus.setButton = 1'b0;
        tick(6);
        bus.setButton = 1'b1;
        tick(15);
        check_val("tmo_pre_q", 32'(bus.Q), 32'd3);
        check_val("tmo_pre_err", 32'(bus.error), 32'd0);
        tick(1);
        check_val("tmo_q", 32'(bus.Q), 32'd0);
        check_val("tmo_err", 32'(bus.error), 32'd1);
        check_val("tmo_operate", 32'(bus.operate), 32'd0);
        press_set(4'h5);
        check_val("err_clr", 32'(bus.error), 32'd0);
        check_val("err_clr_op", 32'(bus.opCode), 32'd5);

        // Display toggles in SEL_R1; stray set press in EXEC is dropped.
        press_disp(1'b1, "disp1");
        press_disp(1'b0, "disp2");
        press_disp(1'b1, "disp3");
        press_set(4'h4);
        check_val("disp_r2_q", 32'(bus.Q), 32'd2);
        bus.inputs    = 4'h6;
        bus.setButton = 1'b0;
        tick(6);
        check_val("disp_exec_q", 32'(bus.Q), 32'd3);
        bus.setButton = 1'b1;
        tick(6);
        bus.inputs    = 4'h5;
        bus.setButton = 1'b0;
        tick(6);
        bus.setButton = 1'b1;
        check_val("stray_q", 32'(bus.Q), 32'd3);
        check_val("stray_r2", 32'(bus.regID2), 32'd6);
        bus.opDone = 1'b1;
        tick(1);
        check_val("disp_rel", 32'(bus.display), 32'd1);
        bus.opDone = 1'b0;
        tick(1);
        check_val("disp_clr_q", 32'(bus.Q), 32'd0);
        check_val("disp_clr", 32'(bus.display), 32'd0);
        tick(8);
        check_val("no_queue_q", 32'(bus.Q), 32'd0);

        // Reset during EXEC drops operate without waiting for a clock edge.
        press_set(4'h0);
        press_set(4'h1);
        bus.inputs    = 4'h2;
        bus.setButton = 1'b0;
        tick(6);
        bus.setButton = 1'b1;
        check_val("pre_rst_operate", 32'(bus.operate), 32'd1);
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_operate", 32'(bus.operate), 32'd0);
        check_val("async_rst_q", 32'(bus.Q), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
